multiplexed_seven_segment_driver: RTL and testbench

//   Drives NUM_DIGITS common-anode seven-segment digits from one shared active-low segment bus.
//   - Time-multiplexes the digits and decodes each 4-bit nibble to hex glyphs 0-F.
//   - Inserts a blanking dead-time between digits to suppress ghosting.
//   - Double-buffers the displayed value so updates take effect only at frame boundaries.
//   - Sits between status/debug logic and the board's display pins.

---
 rtl/multiplexed_seven_segment_driver_if.sv | 41 ++++
 rtl/multiplexed_seven_segment_driver.sv | 160 ++++++++++++++++
 tb/tb_multiplexed_seven_segment_driver.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplexed_seven_segment_driver_if.sv
// rtl/multiplexed_seven_segment_driver_if.sv - display value/control inputs and display pin outputs
//
// Ports carried:
//   i_Value        4*NUM_DIGITS  hex value, nibble k drives digit k
//   i_Load         1             one-cycle strobe capturing i_Value
//   i_Enable       1             0 blanks the display, scanning continues
//   o_Segment_A..G 1 each        active-low segments
//   o_Digit_Sel    NUM_DIGITS    active-low digit enables
//   o_Frame_Start  1             one-cycle pulse at the first output cycle of a frame
// Modports: master (status/debug logic side), slave (driver side).

interface multiplexed_seven_segment_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] i_Value;
    logic                    i_Load;
    logic                    i_Enable;
    logic                    o_Segment_A;
    logic                    o_Segment_B;
    logic                    o_Segment_C;
    logic                    o_Segment_D;
    logic                    o_Segment_E;
    logic                    o_Segment_F;
    logic                    o_Segment_G;
    logic [NUM_DIGITS-1:0]   o_Digit_Sel;
    logic                    o_Frame_Start;

    modport master (
        output i_Value, i_Load, i_Enable,
        input  o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
               o_Segment_E, o_Segment_F, o_Segment_G,
               o_Digit_Sel, o_Frame_Start
    );

    modport slave (
        input  i_Value, i_Load, i_Enable,
        output o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
               o_Segment_E, o_Segment_F, o_Segment_G,
               o_Digit_Sel, o_Frame_Start
    );
endinterface

// File: rtl/multiplexed_seven_segment_driver.sv
// rtl/multiplexed_seven_segment_driver.sv - time-multiplexed hex seven-segment driver with dead-time
//
// Ports:
//   i_Clk    in  system clock, rising edge
//   i_Reset  in  asynchronous active-high reset
//   bus      slave modport of multiplexed_seven_segment_driver_if
//            (i_Value, i_Load, i_Enable in; o_Segment_A..G, o_Digit_Sel, o_Frame_Start out)
// Parameters: NUM_DIGITS (1..8), REFRESH_DIV (> BLANK_CYCLES), BLANK_CYCLES (>= 1)
// Optional feature macro: LEADING_ZERO_BLANK_EN - darkens leading zero digits (digit 0 always shown).

module multiplexed_seven_segment_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                                    i_Clk,
    input  logic                                    i_Reset,
    multiplexed_seven_segment_driver_if.slave       bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic [VAL_W-1:0]      pend_q, pend_d;
    logic                  pv_q, pv_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  fs_q, fs_d;

    logic                  frame_first;
    logic [3:0]            nibble;
    logic                  lz_dark;

    // {A,B,C,D,E,F,G}, active low
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h01;
            4'h1: decode = 7'h4F;
            4'h2: decode = 7'h12;
            4'h3: decode = 7'h06;
            4'h4: decode = 7'h4C;
            4'h5: decode = 7'h24;
            4'h6: decode = 7'h20;
            4'h7: decode = 7'h0F;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h04;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h60;
            4'hC: decode = 7'h31;
            4'hD: decode = 7'h42;
            4'hE: decode = 7'h30;
            default: decode = 7'h38;
        endcase
    endfunction

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            seg_q   <= '1;
            sel_q   <= '1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        seg_d   = '1;
        sel_d   = '1;
        fs_d    = 1'b0;
        nibble  = 4'h0;
        lz_dark = 1'b0;

        // Slot 0 of digit 0 is the frame boundary; this also covers the
        // first cycle after reset because reset parks both counters at zero.
        frame_first = (cnt_q == '0) && (idx_q == '0);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_ON;

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble = disp_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                lz_dark = (k != 0) && ((disp_q >> (4*k)) == '0);
`endif
            end
        end

        // Outputs are a registered image of this cycle's state/index.
        fs_d = frame_first;
        if (bus.i_Enable && (state_q == ST_ON) && !lz_dark) begin
            sel_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = decode(nibble);
        end

        // Double buffer: a load on the boundary cycle bypasses pending so it
        // shows in the frame that is just starting.
        if (frame_first) begin
            if (bus.i_Load) begin
                disp_d = bus.i_Value;
                pv_d   = 1'b0;
            end else if (pv_q) begin
                disp_d = pend_q;
                pv_d   = 1'b0;
            end
        end else if (bus.i_Load) begin
            pend_d = bus.i_Value;
            pv_d   = 1'b1;
        end
    end

    assign bus.o_Segment_A   = seg_q[6];
    assign bus.o_Segment_B   = seg_q[5];
    assign bus.o_Segment_C   = seg_q[4];
    assign bus.o_Segment_D   = seg_q[3];
    assign bus.o_Segment_E   = seg_q[2];
    assign bus.o_Segment_F   = seg_q[1];
    assign bus.o_Segment_G   = seg_q[0];
    assign bus.o_Digit_Sel   = sel_q;
    assign bus.o_Frame_Start = fs_q;

endmodule

// File: tb/tb_multiplexed_seven_segment_driver.sv
// tb/tb_multiplexed_seven_segment_driver.sv - self-checking bench for multiplexed_seven_segment_driver

module tb_multiplexed_seven_segment_driver;
    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    multiplexed_seven_segment_driver_if #(.NUM_DIGITS(ND)) bus();

    multiplexed_seven_segment_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] dut_seg;
    assign dut_seg = {bus.o_Segment_A, bus.o_Segment_B, bus.o_Segment_C, bus.o_Segment_D,
                      bus.o_Segment_E, bus.o_Segment_F, bus.o_Segment_G};

    // Reference model: time since reset release t; slot, digit and frame
    // position are derived arithmetically from t.
    int          t;
    logic [15:0] m_disp, m_pend;
    logic        m_pv;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_sel;
    logic        exp_fs;

    function automatic bit model_dark(int tt, logic [15:0] dv, logic en);
        int d;
        d = (tt / RD) % ND;
        if (!en || (tt % RD) < BC) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (dv >> (4*d)) == 16'h0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_sel(int tt, logic [15:0] dv, logic en);
        if (model_dark(tt, dv, en)) return 4'hF;
        return ~(4'b0001 << ((tt / RD) % ND));
    endfunction

    function automatic logic [6:0] model_seg(int tt, logic [15:0] dv, logic en);
        int d;
        logic [3:0] nib;
        d = (tt / RD) % ND;
        nib = dv[4*d +: 4];
        if (model_dark(tt, dv, en)) return 7'h7F;
        return GLYPH[nib];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t       <= 0;
            m_disp  <= '0;
            m_pend  <= '0;
            m_pv    <= 1'b0;
            exp_seg <= 7'h7F;
            exp_sel <= 4'hF;
            exp_fs  <= 1'b0;
        end else begin
            exp_fs  <= (t % FRAME) == 0;
            exp_sel <= model_sel(t, m_disp, bus.i_Enable);
            exp_seg <= model_seg(t, m_disp, bus.i_Enable);
            if ((t % FRAME) == 0) begin
                if (bus.i_Load) begin
                    m_disp <= bus.i_Value;
                    m_pv   <= 1'b0;
                end else if (m_pv) begin
                    m_disp <= m_pend;
                    m_pv   <= 1'b0;
                end
            end else if (bus.i_Load) begin
                m_pend <= bus.i_Value;
                m_pv   <= 1'b1;
            end
            t <= t + 1;
        end
    end

    task automatic wait_fs(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
            if (bus.o_Frame_Start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.i_Value = v;
        bus.i_Load  = 1'b1;
        @(negedge clk);
        bus.i_Load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_Load = 1'b0; bus.i_Enable = 1'b1; bus.i_Value = '0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (dut_seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", dut_seg); end
        if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=f", bus.o_Digit_Sel); end
        if (bus.o_Frame_Start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", bus.o_Frame_Start); end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.o_Frame_Start !== 1'b1) begin errors++; $display("FAIL first_fs got=%b exp=1", bus.o_Frame_Start); end
        if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL first_blank got=%h exp=f", bus.o_Digit_Sel); end
    endtask

    task automatic test_reset_mid_on();
        int n;
        int pulses;
        n = 0;
        while (bus.o_Digit_Sel === 4'hF && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (bus.o_Digit_Sel === 4'hF) begin errors++; $display("FAIL reach_on got=%h exp=one_low", bus.o_Digit_Sel); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (dut_seg !== 7'h7F) begin errors++; $display("FAIL async_seg got=%h exp=7f", dut_seg); end
        if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL async_sel got=%h exp=f", bus.o_Digit_Sel); end
        if (bus.o_Frame_Start !== 1'b0) begin errors++; $display("FAIL async_fs got=%b exp=0", bus.o_Frame_Start); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.o_Frame_Start !== 1'b1) begin errors++; $display("FAIL rel_fs got=%b exp=1", bus.o_Frame_Start); end
        if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL rel_blank0 got=%h exp=f", bus.o_Digit_Sel); end
        @(negedge clk);
        checks++;
        if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL rel_blank1 got=%h exp=f", bus.o_Digit_Sel); end
        @(negedge clk);
        checks += 2;
        if (bus.o_Digit_Sel !== 4'b1110) begin errors++; $display("FAIL rel_on_sel got=%h exp=e", bus.o_Digit_Sel); end
        if (dut_seg !== 7'h01) begin errors++; $display("FAIL rel_on_seg got=%h exp=01", dut_seg); end
        pulses = 0;
        repeat (FRAME - 3) begin @(negedge clk); if (bus.o_Frame_Start) pulses++; end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rel_fs_once got=%0d exp=0", pulses); end
    endtask

    task automatic test_load_display();
        bit ok;
        logic [6:0] g [4];
        logic [3:0] es;
        logic [6:0] eg;
        g = '{7'h38, 7'h08, 7'h12, 7'h4F};
        repeat ($urandom_range(1, 20)) @(negedge clk);
        do_load(16'h12AF);
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_fs_timeout got=0 exp=1"); end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            es = ((k % RD) < BC) ? 4'hF : ~(4'b0001 << (k / RD));
            eg = ((k % RD) < BC) ? 7'h7F : g[k / RD];
            checks += 2;
            if (bus.o_Digit_Sel !== es) begin errors++; $display("FAIL load_sel k=%0d got=%h exp=%h", k, bus.o_Digit_Sel, es); end
            if (dut_seg !== eg) begin errors++; $display("FAIL load_seg k=%0d got=%h exp=%h", k, dut_seg, eg); end
        end
    endtask

    task automatic test_last_load_wins();
        bit ok;
        logic [6:0] eg;
        wait_fs(ok);
        repeat (3) @(negedge clk);
        do_load(16'h1111);
        repeat (5) @(negedge clk);
        do_load(16'h2222);
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lastload_fs_timeout got=0 exp=1"); end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            eg = ((k % RD) < BC) ? 7'h7F : 7'h12;
            checks++;
            if (dut_seg !== eg) begin errors++; $display("FAIL lastload_seg k=%0d got=%h exp=%h", k, dut_seg, eg); end
        end
        // Now between the 31st and 32nd edge of the frame: this load lands on the boundary cycle.
        do_load(16'h5555);
        checks++;
        if (bus.o_Frame_Start !== 1'b1) begin errors++; $display("FAIL swapload_fs got=%b exp=1", bus.o_Frame_Start); end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            eg = ((k % RD) < BC) ? 7'h7F : 7'h24;
            checks++;
            if (dut_seg !== eg) begin errors++; $display("FAIL swapload_seg k=%0d got=%h exp=%h", k, dut_seg, eg); end
        end
    endtask

    task automatic test_enable();
        bit ok;
        int fs_cyc;
        wait_fs(ok);
        fs_cyc = cyc;
        repeat ($urandom_range(3, 12)) @(negedge clk);
        bus.i_Enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 2;
            if (bus.o_Digit_Sel !== 4'hF) begin errors++; $display("FAIL dis_sel i=%0d got=%h exp=f", i, bus.o_Digit_Sel); end
            if (dut_seg !== 7'h7F) begin errors++; $display("FAIL dis_seg i=%0d got=%h exp=7f", i, dut_seg); end
        end
        bus.i_Enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_fs(ok);
            checks++;
            if (!ok || (cyc - fs_cyc) !== FRAME) begin
                errors++; $display("FAIL en_fs_period got=%0d exp=%0d", cyc - fs_cyc, FRAME);
            end
            fs_cyc = cyc;
        end
    endtask

    task automatic test_free_run();
        bit ok;
        int last_fs, prev, runs, zeros, dig;
        do_load(16'h9876);
        wait_fs(ok);
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL free_fs_timeout got=0 exp=1"); end
        last_fs = cyc; prev = -1; runs = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            zeros = 0; dig = -1;
            for (int b = 0; b < ND; b++) if (bus.o_Digit_Sel[b] === 1'b0) begin zeros++; dig = b; end
            checks += 3;
            if (zeros > 1) begin errors++; $display("FAIL free_onehot k=%0d got=%h exp=one_low", k, bus.o_Digit_Sel); end
            if (bus.o_Digit_Sel !== exp_sel) begin errors++; $display("FAIL free_sel k=%0d got=%h exp=%h", k, bus.o_Digit_Sel, exp_sel); end
            if (dut_seg !== exp_seg) begin errors++; $display("FAIL free_seg k=%0d got=%h exp=%h", k, dut_seg, exp_seg); end
            if (dig >= 0 && dig != prev) begin
                if (prev >= 0) begin
                    checks++;
                    if (dig !== (prev + 1) % ND) begin errors++; $display("FAIL free_order got=%0d exp=%0d", dig, (prev + 1) % ND); end
                end
                prev = dig; runs++;
            end
            if (k > 0 && bus.o_Frame_Start) begin
                checks++;
                if ((cyc - last_fs) !== FRAME) begin errors++; $display("FAIL free_fs_period got=%0d exp=%0d", cyc - last_fs, FRAME); end
                last_fs = cyc;
            end
        end
        checks++;
        if (runs !== 3 * ND) begin errors++; $display("FAIL free_runs got=%0d exp=%0d", runs, 3 * ND); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks += 3;
            if (bus.o_Digit_Sel !== exp_sel) begin errors++; $display("FAIL rnd_sel k=%0d got=%h exp=%h", k, bus.o_Digit_Sel, exp_sel); end
            if (dut_seg !== exp_seg) begin errors++; $display("FAIL rnd_seg k=%0d got=%h exp=%h", k, dut_seg, exp_seg); end
            if (bus.o_Frame_Start !== exp_fs) begin errors++; $display("FAIL rnd_fs k=%0d got=%b exp=%b", k, bus.o_Frame_Start, exp_fs); end
            bus.i_Value  = 16'($urandom);
            bus.i_Load   = ($urandom_range(0, 11) == 0);
            bus.i_Enable = ($urandom_range(0, 9) != 0);
        end
        bus.i_Load   = 1'b0;
        bus.i_Enable = 1'b1;
        @(negedge clk);
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        bit ok;
        logic [3:0] es;
        logic [6:0] eg;
        do_load(16'h0030);
        wait_fs(ok);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            es = 4'hF; eg = 7'h7F;
            if ((k % RD) >= BC && (k / RD) == 1) begin es = 4'b1101; eg = 7'h06; end
            if ((k % RD) >= BC && (k / RD) == 0) begin es = 4'b1110; eg = 7'h01; end
            checks += 2;
            if (bus.o_Digit_Sel !== es) begin errors++; $display("FAIL lz30_sel k=%0d got=%h exp=%h", k, bus.o_Digit_Sel, es); end
            if (dut_seg !== eg) begin errors++; $display("FAIL lz30_seg k=%0d got=%h exp=%h", k, dut_seg, eg); end
        end
        do_load(16'h0000);
        wait_fs(ok);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            es = 4'hF; eg = 7'h7F;
            if ((k % RD) >= BC && (k / RD) == 0) begin es = 4'b1110; eg = 7'h01; end
            checks += 2;
            if (bus.o_Digit_Sel !== es) begin errors++; $display("FAIL lz00_sel k=%0d got=%h exp=%h", k, bus.o_Digit_Sel, es); end
            if (dut_seg !== eg) begin errors++; $display("FAIL lz00_seg k=%0d got=%h exp=%h", k, dut_seg, eg); end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_on();
        test_load_display();
        test_last_load_wins();
        test_enable();
        test_free_run();
        test_random();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
